// File: rtl/median_axis_tx_framer.sv
// median_axis_tx_framer
//   Tags the non-stallable median-filter pixel stream with AXI4-Stream framing
//   (tuser = first pixel of frame, tlast = last pixel of line) and buffers it in a
//   small FIFO so the downstream consumer can apply backpressure.
//
// Ports
//   i_clk, i_aresetn         clock, asynchronous active-low reset
//   WIDTH, HEIGHT            frame geometry, sampled when an SOF beat is accepted
//   i_median_pixel           pixel data
//   i_image_data_valid       pixel qualifier (upstream cannot be stalled)
//   i_start_of_frame         first pixel of a frame, qualified by valid
//   m_axis_t*                AXI4-Stream master (tdata/tvalid/tuser/tlast/tready)
//   o_overflow               sticky: a beat was dropped on a full FIFO (cleared by SOF)
//   o_frame_done             one-cycle pulse after the last pixel of a frame is taken
//
// Optional build macro MEDIAN_TX_STATS_EN adds o_frame_count (wrapping) and
// o_drop_count (saturating) 16-bit statistics outputs.
module median_axis_tx_framer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIM_WIDTH  = 13
) (
   input  logic                  i_clk,
   input  logic                  i_aresetn,
   input  logic [DIM_WIDTH-1:0]  WIDTH,
   input  logic [DIM_WIDTH-1:0]  HEIGHT,
   input  logic [DATA_WIDTH-1:0] i_median_pixel,
   input  logic                  i_image_data_valid,
   input  logic                  i_start_of_frame,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  o_overflow,
   output logic                  o_frame_done
`ifdef MEDIAN_TX_STATS_EN
   ,
   output logic [15:0]           o_frame_count,
   output logic [15:0]           o_drop_count
`endif
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW = AW + 1;
   localparam int unsigned EntW = DATA_WIDTH + 2;

   typedef enum logic [0:0] {StWaitSof, StActive} state_e;

   state_e               state_q, state_d;
   logic [DIM_WIDTH-1:0] w_q, w_d, h_q, h_d;
   logic [DIM_WIDTH-1:0] col_q, col_d, row_q, row_d;
   logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic                 ovf_q, ovf_d, done_q, done_d;
   logic [EntW-1:0]      mem_q [FIFO_DEPTH];

   logic                 empty, full, rd_en, wr_en, drop;
   logic                 beat_wr, wr_user, wr_last;
   logic [DIM_WIDTH-1:0] w_sof, h_sof;
   logic [EntW-1:0]      rd_entry;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rd_en = !empty && m_axis_tready;

   // Zero geometry is treated as 1 so the counters always have a terminal value.
   assign w_sof = (WIDTH  == '0) ? DIM_WIDTH'(1) : WIDTH;
   assign h_sof = (HEIGHT == '0) ? DIM_WIDTH'(1) : HEIGHT;

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      beat_wr = 1'b0;
      wr_user = 1'b0;
      wr_last = 1'b0;

      if (i_image_data_valid) begin
         if (i_start_of_frame) begin
            // SOF restarts framing from any state; a truncated frame gets no tlast.
            w_d     = w_sof;
            h_d     = h_sof;
            ovf_d   = 1'b0;
            beat_wr = 1'b1;
            wr_user = 1'b1;
            if (w_sof == DIM_WIDTH'(1)) begin
               wr_last = 1'b1;
               col_d   = '0;
               if (h_sof == DIM_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  row_d   = '0;
                  state_d = StWaitSof;
               end else begin
                  row_d   = DIM_WIDTH'(1);
                  state_d = StActive;
               end
            end else begin
               col_d   = DIM_WIDTH'(1);
               row_d   = '0;
               state_d = StActive;
            end
         end else if (state_q == StActive) begin
            beat_wr = 1'b1;
            wr_last = (col_q == w_q - DIM_WIDTH'(1));
            if (wr_last) begin
               col_d = '0;
               if (row_q == h_q - DIM_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  row_d   = '0;
                  state_d = StWaitSof;
               end else begin
                  row_d = row_q + DIM_WIDTH'(1);
               end
            end else begin
               col_d = col_q + DIM_WIDTH'(1);
            end
         end
      end

      // A simultaneous read frees the slot, so a write on a full FIFO is still taken.
      wr_en = beat_wr && (!full || rd_en);
      drop  = beat_wr && !wr_en;
      if (drop) begin
         ovf_d = 1'b1;
      end
      wptr_d = wptr_q + PtrW'(wr_en);
      rptr_d = rptr_q + PtrW'(rd_en);
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= StWaitSof;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         row_q   <= row_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wptr_q[AW-1:0]] <= {wr_user, wr_last, i_median_pixel};
      end
   end

   assign rd_entry      = mem_q[rptr_q[AW-1:0]];
   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = empty ? '0 : rd_entry[DATA_WIDTH-1:0];
   assign m_axis_tlast  = !empty && rd_entry[DATA_WIDTH];
   assign m_axis_tuser  = !empty && rd_entry[DATA_WIDTH+1];
   assign o_overflow    = ovf_q;
   assign o_frame_done  = done_q;

`ifdef MEDIAN_TX_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q + 16'(done_d);
      drop_cnt_d  = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign o_frame_count = frame_cnt_q;
   assign o_drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_median_axis_tx_framer.sv
// Directed bench for median_axis_tx_framer: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge, accepted beats are collected by a
// monitor and compared against hand-written expected streams.
module tb_median_axis_tx_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] width = 13'd4;
   logic [12:0] height = 13'd2;
   logic [7:0]  pix = 8'd0;
   logic        vld = 1'b0;
   logic        sof = 1'b0;
   logic [7:0]  tdata;
   logic        tvalid, tuser, tlast;
   logic        tready = 1'b1;
   logic        ovf, fdone;
`ifdef MEDIAN_TX_STATS_EN
   logic [15:0] frame_count, drop_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [9:0] got_q [$];
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   median_axis_tx_framer dut (
      .i_clk              (clk),
      .i_aresetn          (rst_n),
      .WIDTH              (width),
      .HEIGHT             (height),
      .i_median_pixel     (pix),
      .i_image_data_valid (vld),
      .i_start_of_frame   (sof),
      .m_axis_tdata       (tdata),
      .m_axis_tvalid      (tvalid),
      .m_axis_tuser       (tuser),
      .m_axis_tlast       (tlast),
      .m_axis_tready      (tready),
      .o_overflow         (ovf),
      .o_frame_done       (fdone)
`ifdef MEDIAN_TX_STATS_EN
      ,
      .o_frame_count      (frame_count),
      .o_drop_count       (drop_count)
`endif
   );

   // A beat seen valid&&ready at the falling edge transfers on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && tvalid && tready) got_q.push_back({tuser, tlast, tdata});
      if (rst_n && fdone) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle of upstream input.
   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      @(posedge clk);
      #1;
      vld = v;
      sof = s;
      pix = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      vld   = 1'b0;
      sof   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic expect_beat(input logic u, input logic l, input logic [7:0] d);
      exp_q.push_back({u, l, d});
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   initial begin
      int unstable;

      // Reset state
      #2;
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_tuser", tuser, 0);
      check("rst_tlast", tlast, 0);
      check("rst_ovf", ovf, 0);
      check("rst_fdone", fdone, 0);
      do_reset();

      // 1: 4x2 frame, no backpressure, latency and frame_done timing
      width = 13'd4; height = 13'd2; tready = 1'b1;
      drive(1'b1, 1'b1, 8'd1);
      @(negedge clk);
      check("t1_lat_before", tvalid, 0);
      drive(1'b1, 1'b0, 8'd2);
      @(negedge clk);
      check("t1_lat_after", tvalid, 1);
      for (int i = 3; i <= 8; i++) drive(1'b1, 1'b0, 8'(i));
      @(negedge clk);
      check("t1_fdone_early", fdone, 0);
      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("t1_fdone_pulse", fdone, 1);
      idle(4);
      for (int i = 1; i <= 8; i++) expect_beat(i == 1, (i == 4) || (i == 8), 8'(i));
      check_stream("t1");
      check("t1_done_cnt", done_cnt, 1);
      check("t1_ovf", ovf, 0);
`ifdef MEDIAN_TX_STATS_EN
      check("t1_frame_count", frame_count, 1);
`endif

      // 2: same frame, tready low for 10 cycles
      do_reset();
      tready   = 1'b0;
      unstable = 0;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, i == 1, 8'(i));
         @(negedge clk);
         if (i >= 2 && (tdata !== 8'd1 || tuser !== 1'b1 || tvalid !== 1'b1)) unstable++;
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 8'h00);
         @(negedge clk);
         if (tdata !== 8'd1 || tuser !== 1'b1 || tvalid !== 1'b1) unstable++;
      end
      check("t2_stall_stable", unstable, 0);
      check("t2_no_drain", got_q.size(), 0);
      tready = 1'b1;
      idle(12);
      for (int i = 1; i <= 8; i++) expect_beat(i == 1, (i == 4) || (i == 8), 8'(i));
      check_stream("t2");
      check("t2_empty", tvalid, 0);

      // 3: overflow, 20 beats into a 16-deep FIFO
      do_reset();
      width = 13'd20; height = 13'd1; tready = 1'b0;
      for (int i = 1; i <= 20; i++) drive(1'b1, i == 1, 8'(i));
      idle(2);
      check("t3_ovf", ovf, 1);
`ifdef MEDIAN_TX_STATS_EN
      check("t3_drop_count", drop_count, 4);
`endif
      tready = 1'b1;
      idle(20);
      for (int i = 1; i <= 16; i++) expect_beat(i == 1, 1'b0, 8'(i));
      check_stream("t3");
      check("t3_ovf_sticky", ovf, 1);

      // 4: non-SOF beats in WAIT_SOF are discarded
      do_reset();
      width = 13'd4; height = 13'd1;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hA0 + 8'(i));
      for (int i = 1; i <= 4; i++) drive(1'b1, i == 1, 8'(i));
      idle(4);
      for (int i = 1; i <= 4; i++) expect_beat(i == 1, i == 4, 8'(i));
      check_stream("t4");
      check("t4_ovf", ovf, 0);
      check("t4_done_cnt", done_cnt, 1);

      // 5: early SOF truncates a frame and restarts counters
      do_reset();
      width = 13'd4; height = 13'd2;
      for (int i = 1; i <= 5; i++) drive(1'b1, i == 1, 8'(i));
      for (int i = 11; i <= 14; i++) drive(1'b1, i == 11, 8'(i));
      idle(4);
      for (int i = 1; i <= 5; i++) expect_beat(i == 1, i == 4, 8'(i));
      for (int i = 11; i <= 14; i++) expect_beat(i == 11, i == 14, 8'(i));
      check_stream("t5");
      check("t5_done_cnt", done_cnt, 0);

      // 5b: W=1,H=1 gives tuser+tlast and frame_done on the SOF beat
      do_reset();
      width = 13'd1; height = 13'd1;
      drive(1'b1, 1'b1, 8'h5A);
      drive(1'b1, 1'b0, 8'h5B);
      idle(3);
      expect_beat(1'b1, 1'b1, 8'h5A);
      check_stream("t5b");
      check("t5b_done_cnt", done_cnt, 1);

      // 6: asynchronous reset with 6 entries buffered
      do_reset();
      width = 13'd4; height = 13'd2; tready = 1'b0;
      for (int i = 1; i <= 6; i++) drive(1'b1, i == 1, 8'(i));
      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("t6_pre_tvalid", tvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_tvalid", tvalid, 0);
      check("t6_rst_ovf", ovf, 0);
      check("t6_rst_tdata", tdata, 0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      tready = 1'b1;
      got_q.delete();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'hEE);
      idle(3);
      check("t6_no_stale", got_q.size(), 0);
      check("t6_tvalid_idle", tvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/median_axis_tx_framer.md
Name: median_axis_tx_framer

Overview:
- Output stage that sits directly downstream of the median processing stage.
- Accepts the filtered pixel stream, which has no backpressure, and tags each pixel with AXI4-Stream framing: tuser on the first pixel of a frame, tlast on the last pixel of each line.
- Buffers pixels in a small FIFO so the downstream consumer can apply m_axis_tready backpressure.
- Frame geometry is taken at run time from WIDTH/HEIGHT.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 4.
- DIM_WIDTH, 13, width of the WIDTH/HEIGHT inputs and of the internal column/row counters.

Ports:
- i_clk  in  1  clock.
- i_aresetn  in  1  reset, asynchronous, active-low.
- WIDTH  in  DIM_WIDTH  pixels per line; sampled on SOF acceptance.
- HEIGHT  in  DIM_WIDTH  lines per frame; sampled on SOF acceptance.
- i_median_pixel  in  DATA_WIDTH  filtered pixel.
- i_image_data_valid  in  1  pixel qualifier; upstream cannot be stalled.
- i_start_of_frame  in  1  marks the first pixel of a frame; meaningful only with valid.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- m_axis_tready  in  1  downstream ready.
- o_overflow  out  1  sticky flag: a pixel was dropped.
- o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is written into the FIFO.

Behaviour:
- Reset: clock and reset are as already decided — one clock, reset asynchronous and active-low.
  - FIFO emptied; FSM goes to WAIT_SOF.
  - Counters are 0.
  - All outputs are 0: m_axis_tdata, tvalid, tuser, tlast, o_overflow, o_frame_done.
  - Reset asserted mid-frame discards all buffered pixels immediately.
- Input beat = i_image_data_valid high on a rising edge.
- FSM, write side:
  - WAIT_SOF: beats without SOF are discarded; no overflow is flagged. A beat with SOF does the following:
    - latches W=max(WIDTH,1) and H=max(HEIGHT,1);
    - sets col=0, row=0;
    - clears o_overflow;
    - writes the pixel with tuser=1;
    - moves to ACTIVE.
  - ACTIVE, beat without SOF: writes the pixel with tuser=0 and tlast=(col==W-1).
    - col increments, and wraps to 0 at W-1; row then increments.
    - If row==H-1 and col==W-1: pulse o_frame_done and go to WAIT_SOF.
  - ACTIVE, beat with SOF (early next frame): handled exactly like SOF in WAIT_SOF, i.e. re-latch, restart the counters, tuser=1. The stream resynchronises; no tlast is inserted for the truncated frame.
  - W=1 case: the SOF pixel carries tuser=1 and tlast=1 together. If H is also 1, o_frame_done pulses on that same beat and the FSM stays in WAIT_SOF.
- FIFO entry = {tuser, tlast, data}.
  - Read occurs when m_axis_tvalid && m_axis_tready.
  - m_axis_tvalid = FIFO not empty.
  - Outputs are registered. Latency from write into an empty FIFO to tvalid is 1 cycle.
  - Data, tuser and tlast hold stable while tvalid=1 and tready=0.
- Full FIFO:
  - A write in the same cycle as a read is accepted; occupancy is unchanged.
  - A write when full without a read is dropped and o_overflow is set.
  - Counters still advance on a dropped beat, so later tlast/tuser positions stay correct.
  - A dropped SOF still re-latches geometry and counters, but its tuser marker is lost.
- Empty FIFO: a read is impossible (tvalid=0). A write into an empty FIFO with tready=1 appears on the next cycle.
- WIDTH/HEIGHT changes mid-frame have no effect until the next SOF.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty are decoded from the MSB comparison.

Optional Feature:
- Macro MEDIAN_TX_STATS_EN.
- Defined: adds two output ports.
  - o_frame_count (16 bits): increments on each o_frame_done and wraps at 0xFFFF→0.
  - o_drop_count (16 bits): increments per dropped beat and saturates at 0xFFFF.
  - Both reset to 0. Neither is cleared by SOF.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, HEIGHT=2, tready=1, SOF plus 8 contiguous beats with data 1..8 → 8 output beats with data 1..8 in order:
  - tuser only on data 1;
  - tlast on data 4 and 8;
  - o_frame_done pulses once, on the write of data 8;
  - first tvalid appears 1 cycle after the first write.
- Same frame with tready=0 for the first 10 cycles → FIFO holds 8 entries; tdata=1, tuser=1 stay stable throughout the stall, then all 8 drain in order with the same framing.
- FIFO_DEPTH=16, tready=0, SOF plus 20 beats (WIDTH=20, HEIGHT=1) → 16 stored, 4 dropped, o_overflow=1. With MEDIAN_TX_STATS_EN defined, o_drop_count=4.
- 3 beats with SOF=0 in WAIT_SOF, then SOF plus 4 beats (WIDTH=4, HEIGHT=1) → only 4 pixels are output, with tuser on the first and tlast on the fourth; o_overflow stays 0.
- WIDTH=4, HEIGHT=2: SOF plus 5 beats, then a new SOF → output tlast on beat 4; the new SOF pixel carries tuser=1 and counters restart (tlast on its 4th pixel).
- i_aresetn pulsed low while the FIFO holds 6 entries → tvalid=0 and o_overflow=0 immediately. After release, no stale data appears and the FSM waits for SOF.
